// File: rtl/text_console_writer.sv
// Terminal-style character writer: turns received SPI bytes into character-RAM
// writes on a COLS x ROWS grid, with CR/LF/BS/FF handling and sequential clears.
module text_console_writer #(
  parameter int unsigned COLS   = 80,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy,
  output logic              overflow
);

  localparam logic [6:0]        LastCol  = 7'(COLS - 1);
  localparam logic [4:0]        LastRow  = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ColsA    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LastLine = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LastAll  = ADDR_W'(COLS * ROWS - 1);

  typedef enum logic [1:0] {StIdle, StClrLine, StClrAll} state_e;

  state_e            state_q, state_d;
  logic [6:0]        col_q, col_d;
  logic [4:0]        row_q, row_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  // done_q: the last clear write has been issued; spend one more busy cycle.
  logic              done_q, done_d;
  logic [7:0]        hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              overflow_q, overflow_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              busy_q, busy_d;

  logic              take;
  logic [7:0]        cur_byte;
  logic              is_print, is_cr, is_lf, is_bs, is_ff;
  logic [4:0]        row_next;
  logic [ADDR_W-1:0] row_base, next_base, clr_last;

  // Byte source select: a held byte always wins over a fresh one in IDLE.
  always_comb begin
    take     = 1'b0;
    cur_byte = rx_byte;
    if (state_q == StIdle) begin
      if (hold_full_q) begin
        take     = 1'b1;
        cur_byte = hold_q;
      end else if (rx_valid) begin
        take = 1'b1;
      end
    end
  end

  assign is_print  = take && (cur_byte >= 8'h20) && (cur_byte <= 8'h7e);
  assign is_cr     = take && (cur_byte == 8'h0d);
  assign is_lf     = take && (cur_byte == 8'h0a);
  assign is_bs     = take && (cur_byte == 8'h08) && (col_q != 7'd0);
  assign is_ff     = take && (cur_byte == 8'h0c);
  assign row_next  = (row_q == LastRow) ? 5'd0 : row_q + 5'd1;
  assign row_base  = ADDR_W'(row_q) * ColsA;
  assign next_base = ADDR_W'(row_next) * ColsA;
  assign clr_last  = (state_q == StClrLine) ? LastLine : LastAll;

  // Next state: cursor, clear counter, hold register and sticky overflow.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    overflow_d  = overflow_q;

    if (state_q == StIdle) begin
      // Held byte is consumed now, so a simultaneous arrival has nowhere to go.
      if (hold_full_q) begin
        hold_full_d = 1'b0;
        if (rx_valid) overflow_d = 1'b1;
      end
    end else if (rx_valid) begin
      if (hold_full_q) begin
        overflow_d = 1'b1;
      end else begin
        hold_full_d = 1'b1;
        hold_d      = rx_byte;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (is_print) begin
          if (col_q == LastCol) begin
            col_d   = 7'd0;
            row_d   = row_next;
            state_d = StClrLine;
            cnt_d   = '0;
            done_d  = 1'b0;
          end else begin
            col_d = col_q + 7'd1;
          end
        end else if (is_cr) begin
          col_d = 7'd0;
        end else if (is_lf) begin
          // First clear write goes out with the acceptance itself.
          col_d   = 7'd0;
          row_d   = row_next;
          state_d = StClrLine;
          cnt_d   = ADDR_W'(1);
          done_d  = (LastLine == '0);
        end else if (is_bs) begin
          col_d = col_q - 7'd1;
        end else if (is_ff) begin
          col_d   = 7'd0;
          row_d   = 5'd0;
          state_d = StClrAll;
          cnt_d   = ADDR_W'(1);
          done_d  = (LastAll == '0);
        end
      end
      StClrLine, StClrAll: begin
        if (done_q) begin
          state_d = StIdle;
          done_d  = 1'b0;
        end else if (cnt_q == clr_last) begin
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode: the write port value for the next cycle.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = (state_d != StIdle);
    unique case (state_q)
      StIdle: begin
        if (is_print) begin
          wr_en_d   = 1'b1;
          wr_addr_d = row_base + ADDR_W'(col_q);
          wr_data_d = cur_byte;
        end else if (is_bs) begin
          wr_en_d   = 1'b1;
          wr_addr_d = row_base + ADDR_W'(col_q - 7'd1);
          wr_data_d = 8'h20;
        end else if (is_lf) begin
          wr_en_d   = 1'b1;
          wr_addr_d = next_base;
          wr_data_d = 8'h20;
        end else if (is_ff) begin
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = 8'h20;
        end
      end
      StClrLine: begin
        if (!done_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = row_base + cnt_q;
          wr_data_d = 8'h20;
        end
      end
      StClrAll: begin
        if (!done_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q;
          wr_data_d = 8'h20;
        end
      end
      default: wr_en_d = 1'b0;
    endcase
  end

  // State register; reset aborts any clear in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      overflow_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      overflow_q  <= overflow_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign busy       = busy_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: directed timing checks plus randomized bytes
// compared against a behavioural screen-writer model.
module tb_text_console_writer;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_byte = 8'h00;
  logic              rx_valid = 1'b0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [6:0]        cursor_col;
  logic [4:0]        cursor_row;
  logic              busy;
  logic              overflow;

  int n_checks = 0;
  int n_errors = 0;
  int mcol = 0;
  int mrow = 0;
  logic [ADDR_W+7:0] exp_q[$];
  logic [ADDR_W+7:0] got_q[$];

  text_console_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Capture every character-RAM write.
  always @(negedge clk) if (wr_en) got_q.push_back({wr_addr, wr_data});

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [ADDR_W+7:0] pack(input int a, input logic [7:0] d);
    return {ADDR_W'(a), d};
  endfunction

  // Reference: what the screen writer must emit for one byte, in order.
  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7e) begin
      exp_q.push_back(pack(mrow * COLS + mcol, b));
      if (mcol == COLS - 1) begin
        mcol = 0;
        mrow = (mrow + 1) % ROWS;
        for (int c = 0; c < COLS; c++) exp_q.push_back(pack(mrow * COLS + c, 8'h20));
      end else begin
        mcol++;
      end
    end else if (b == 8'h0d) begin
      mcol = 0;
    end else if (b == 8'h0a) begin
      mcol = 0;
      mrow = (mrow + 1) % ROWS;
      for (int c = 0; c < COLS; c++) exp_q.push_back(pack(mrow * COLS + c, 8'h20));
    end else if (b == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        exp_q.push_back(pack(mrow * COLS + mcol, 8'h20));
      end
    end else if (b == 8'h0c) begin
      mcol = 0;
      mrow = 0;
      for (int a = 0; a < COLS * ROWS; a++) exp_q.push_back(pack(a, 8'h20));
    end
  endtask

  // One-cycle strobe; returns at the negedge of the cycle after acceptance.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] b;
    int r;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_outs", {wr_en, busy, overflow, wr_addr, wr_data}, 32'd0);
    check_eq("rst_cursor", {cursor_col, cursor_row}, 32'd0);

    // 'A' at home
    send_byte(8'h41);
    check_eq("a_wr", {wr_en, wr_addr, wr_data}, {1'b1, 12'd0, 8'h41});
    check_eq("a_cursor", {cursor_col, cursor_row}, {7'd1, 5'd0});
    @(negedge clk);
    check_eq("a_once", 32'(wr_en), 32'd0);

    // Fill to last column, then wrap with 'Z'
    for (int i = 0; i < 78; i++) send_byte(8'(32 + $urandom_range(0, 94)));
    check_eq("col79", 32'(cursor_col), 32'd79);
    send_byte(8'h5a);
    check_eq("z_wr", {busy, wr_en, wr_addr, wr_data}, {1'b1, 1'b1, 12'd79, 8'h5a});
    check_eq("z_cursor", {cursor_col, cursor_row}, {7'd0, 5'd1});
    for (int i = 0; i < COLS; i++) begin
      @(negedge clk);
      check_eq("z_clr", {busy, wr_en, wr_addr, wr_data}, {1'b1, 1'b1, 12'(80 + i), 8'h20});
    end
    @(negedge clk);
    check_eq("z_done", {busy, wr_en}, 32'd0);

    // LF from row 29 wraps to row 0 and clears it
    for (int i = 0; i < 28; i++) begin
      send_byte(8'h0a);
      wait_idle();
    end
    for (int i = 0; i < 5; i++) send_byte(8'h61);
    check_eq("r29_cursor", {cursor_col, cursor_row}, {7'd5, 5'd29});
    send_byte(8'h0a);
    check_eq("lf_cursor", {cursor_col, cursor_row}, 32'd0);
    check_eq("lf_clr0", {busy, wr_en, wr_addr, wr_data}, {1'b1, 1'b1, 12'd0, 8'h20});
    for (int i = 1; i < COLS; i++) begin
      @(negedge clk);
      check_eq("lf_clr", {busy, wr_en, wr_addr, wr_data}, {1'b1, 1'b1, 12'(i), 8'h20});
    end
    @(negedge clk);
    check_eq("lf_done", {busy, wr_en}, 32'd0);

    // FF clears whole screen in order
    send_byte(8'h0c);
    check_eq("ff_cursor", {cursor_col, cursor_row}, 32'd0);
    check_eq("ff_clr0", {busy, wr_en, wr_addr, wr_data}, {1'b1, 1'b1, 12'd0, 8'h20});
    for (int i = 1; i < COLS * ROWS; i++) begin
      @(negedge clk);
      check_eq("ff_clr", {busy, wr_en, wr_addr, wr_data}, {1'b1, 1'b1, 12'(i), 8'h20});
    end
    @(negedge clk);
    check_eq("ff_done", {busy, wr_en}, 32'd0);

    // X held during clear, Y dropped
    send_byte(8'h0c);
    repeat (100) @(negedge clk);
    send_byte(8'h58);
    check_eq("x_no_ovf", 32'(overflow), 32'd0);
    repeat (10) @(negedge clk);
    send_byte(8'h59);
    check_eq("y_ovf", 32'(overflow), 32'd1);
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq("hold_idle", {busy, wr_en}, 32'd0);
    @(negedge clk);
    check_eq("x_wr", {wr_en, wr_addr, wr_data}, {1'b1, 12'd0, 8'h58});
    check_eq("x_cursor", {cursor_col, cursor_row}, {7'd1, 5'd0});
    @(negedge clk);
    check_eq("y_never", {wr_en, overflow}, {1'b0, 1'b1});
    repeat (3) @(negedge clk);
    check_eq("y_cursor", 32'(cursor_col), 32'd1);

    // Reset in the middle of a full clear
    send_byte(8'h0c);
    repeat (1000) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("mid_rst", {wr_en, busy, overflow, cursor_col, cursor_row}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_quiet", 32'(wr_en), 32'd0);
    end
    send_byte(8'h08);
    check_eq("bs0_wr", 32'(wr_en), 32'd0);
    check_eq("bs0_cursor", {cursor_col, cursor_row}, 32'd0);

    // rx in last busy cycle is held; rx in first idle cycle is dropped
    send_byte(8'h0a);
    repeat (79) @(negedge clk);
    rx_byte  = 8'h48;
    rx_valid = 1'b1;
    @(negedge clk);
    check_eq("last_busy_drop", 32'(busy), 32'd0);
    rx_byte = 8'h4a;
    @(negedge clk);
    rx_valid = 1'b0;
    check_eq("h_wr", {wr_en, wr_addr, wr_data}, {1'b1, 12'd80, 8'h48});
    check_eq("j_ovf", {overflow, cursor_col, cursor_row}, {1'b1, 7'd1, 5'd1});
    @(negedge clk);
    check_eq("j_never", 32'(wr_en), 32'd0);

    // Randomized bytes against the model, from a fresh reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mcol = 0;
    mrow = 0;
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      b = 8'(32 + $urandom_range(0, 94));
      else if (r < 68) b = 8'h0d;
      else if (r < 78) b = 8'h0a;
      else if (r < 88) b = 8'h08;
      else if (r < 90) b = 8'h0c;
      else             b = 8'($urandom_range(0, 255));
      exp_q.delete();
      got_q.delete();
      model_byte(b);
      send_byte(b);
      wait_idle();
      @(negedge clk);
      check_eq("rnd_nwr", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
        check_eq("rnd_wr", 32'(got_q[i]), 32'(exp_q[i]));
      check_eq("rnd_cursor", {cursor_col, cursor_row}, {7'(mcol), 5'(mrow)});
    end
    check_eq("rnd_ovf", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
